// File: rtl/cronometro_bcd.sv
// Four-digit BCD stopwatch: synchronized start/stop, clear and lap buttons drive
// an IDLE/RUN/PAUSE controller, a tick prescaler and a carry-chained BCD counter.
module cronometro_bcd #(
  parameter int N   = 4,
  parameter int DIV = 5_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_ss,
  input  logic         btn_clr,
  input  logic         btn_lap,
  output logic [N-1:0] count,
  output logic [N-1:0] dec,
  output logic [N-1:0] cent,
  output logic [N-1:0] mil,
  output logic         running,
  output logic         ovf
);

  localparam int            PW        = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [N-1:0]  NINE      = N'(9);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  // Button vectors are ordered {lap, clr, ss}.
  logic [2:0]          sync1_q, sync1_d;
  logic [2:0]          sync2_q, sync2_d;
  logic [2:0]          prev_q, prev_d;
  state_t              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [3:0][N-1:0]   dig_q, dig_d;
  logic [3:0][N-1:0]   lap_q, lap_d;
  logic                hold_q, hold_d;
  logic                running_q, running_d;
  logic                ovf_q, ovf_d;

  logic [2:0]          ev;
  logic                tick;
  logic                carry;

  always_comb begin
    sync1_d   = {btn_lap, btn_clr, btn_ss};
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    ev        = sync2_q & ~prev_q;
    tick      = (state_q == RUN) && (presc_q == PRESC_MAX);

    state_d   = state_q;
    presc_d   = presc_q;
    dig_d     = dig_q;
    lap_d     = lap_q;
    hold_d    = hold_q;
    ovf_d     = 1'b0;
    carry     = 1'b0;

    if (ev[1]) begin
      state_d = IDLE;
      presc_d = '0;
      dig_d   = '0;
      lap_d   = '0;
      hold_d  = 1'b0;
    end else begin
      if (state_q == RUN) begin
        presc_d = tick ? '0 : presc_q + PW'(1);
      end
      // A tick ripples a carry through the digits; each digit wraps 9 -> 0.
      if (tick) begin
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (carry) begin
            if (dig_q[i] == NINE) begin
              dig_d[i] = '0;
            end else begin
              dig_d[i] = dig_q[i] + N'(1);
              carry    = 1'b0;
            end
          end
        end
        ovf_d = carry;
      end

      if (ev[0]) begin
        case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = PAUSE;
          PAUSE:   state_d = RUN;
          default: state_d = IDLE;
        endcase
      end

      if (ev[2]) begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else if (state_q == RUN) begin
          lap_d  = dig_q;
          hold_d = 1'b1;
        end
      end
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      state_q   <= IDLE;
      presc_q   <= '0;
      dig_q     <= '0;
      lap_q     <= '0;
      hold_q    <= 1'b0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      presc_q   <= presc_d;
      dig_q     <= dig_d;
      lap_q     <= lap_d;
      hold_q    <= hold_d;
      running_q <= running_d;
      ovf_q     <= ovf_d;
    end
  end

  // While a lap is held the frozen copy is shown; otherwise the live digits.
  assign count   = hold_q ? lap_q[0] : dig_q[0];
  assign dec     = hold_q ? lap_q[1] : dig_q[1];
  assign cent    = hold_q ? lap_q[2] : dig_q[2];
  assign mil     = hold_q ? lap_q[3] : dig_q[3];
  assign running = running_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_cronometro_bcd.sv
// Self-checking bench for cronometro_bcd: an integer-valued stopwatch model is
// compared every cycle, alongside directed checks with hand-computed values.
module tb_cronometro_bcd;

  localparam int DIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_ss, btn_clr, btn_lap;
  logic [3:0] count, dec, cent, mil;
  logic       running, ovf;

  int  total = 0;
  int  passes = 0;
  bit  cmp_en = 1'b0;

  int  m_st = M_IDLE, m_phase = 0, m_cnt = 0, m_lap = 0;
  bit  m_hold = 1'b0, m_ovf = 1'b0;
  bit [2:0] p1 = '0, p2 = '0, p3 = '0;

  cronometro_bcd #(.N(4), .DIV(DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_ss  (btn_ss),
    .btn_clr (btn_clr),
    .btn_lap (btn_lap),
    .count   (count),
    .dec     (dec),
    .cent    (cent),
    .mil     (mil),
    .running (running),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int got, input int exp);
    total++;
    if (got == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
  endtask

  function automatic int dispValue();
    return int'(mil) * 1000 + int'(cent) * 100 + int'(dec) * 10 + int'(count);
  endfunction

  task automatic checkDisp(input string name, input int exp);
    checkOutput(name, dispValue(), exp);
  endtask

  task automatic applyStimulus(input bit ss, input bit clr, input bit lap, input int cycles);
    btn_ss  = ss;
    btn_clr = clr;
    btn_lap = lap;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitDisplay(input int val, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (dispValue() == val) return;
      @(negedge clk);
    end
    checkOutput("wait_display_timeout", dispValue(), val);
  endtask

  // Stopwatch model: a button takes effect at the edge where its sample from two
  // edges ago was high and from three edges ago was low.
  always @(posedge clk or negedge rst) begin : model
    int n_st, n_phase, n_cnt, n_lap;
    bit n_hold, n_ovf;
    bit [2:0] evm;
    if (!rst) begin
      m_st <= M_IDLE; m_phase <= 0; m_cnt <= 0; m_lap <= 0;
      m_hold <= 1'b0; m_ovf <= 1'b0;
      p1 <= '0; p2 <= '0; p3 <= '0;
    end else begin
      evm = p2 & ~p3;
      n_st = m_st; n_phase = m_phase; n_cnt = m_cnt; n_lap = m_lap;
      n_hold = m_hold; n_ovf = 1'b0;
      if (evm[1]) begin
        n_st = M_IDLE; n_phase = 0; n_cnt = 0; n_hold = 1'b0;
      end else begin
        if (m_st == M_RUN) begin
          if (m_phase == DIV - 1) begin
            n_phase = 0;
            n_ovf   = (m_cnt == 9999);
            n_cnt   = (m_cnt + 1) % 10000;
          end else begin
            n_phase = m_phase + 1;
          end
        end
        if (evm[0]) n_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
        if (evm[2]) begin
          if (m_hold) n_hold = 1'b0;
          else if (m_st == M_RUN) begin
            n_lap  = m_cnt;
            n_hold = 1'b1;
          end
        end
      end
      p3 <= p2; p2 <= p1; p1 <= {btn_lap, btn_clr, btn_ss};
      m_st <= n_st; m_phase <= n_phase; m_cnt <= n_cnt; m_lap <= n_lap;
      m_hold <= n_hold; m_ovf <= n_ovf;
    end
  end

  always @(negedge clk) begin : compare
    int d;
    if (cmp_en) begin
      d = m_hold ? m_lap : m_cnt;
      checkOutput("model_count",   int'(count),   d % 10);
      checkOutput("model_dec",     int'(dec),     (d / 10) % 10);
      checkOutput("model_cent",    int'(cent),    (d / 100) % 10);
      checkOutput("model_mil",     int'(mil),     (d / 1000) % 10);
      checkOutput("model_running", int'(running), int'(m_st == M_RUN));
      checkOutput("model_ovf",     int'(ovf),     int'(m_ovf));
    end
  end

  initial begin
    int changes;
    bit prev_run;
    rst = 1'b1; btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    checkDisp("reset_display", 0);
    checkOutput("reset_running", int'(running), 0);
    checkOutput("reset_ovf", int'(ovf), 0);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("idle_after_reset", int'(running), 0);

    // First start: running three edges after the press, first tick DIV edges later.
    btn_ss = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("start_latency_early", int'(running), 0);
    @(negedge clk);
    checkOutput("start_latency", int'(running), 1);
    checkDisp("start_display", 0);
    btn_ss = 1'b0;
    repeat (3) @(negedge clk);
    checkDisp("first_tick_early", 0);
    @(negedge clk);
    checkDisp("first_tick", 1);

    // Pause at 0040, stay frozen, then resume with the retained prescaler phase.
    waitDisplay(40, 400);
    checkDisp("reach_40", 40);
    applyStimulus(1, 0, 0, 3);
    btn_ss = 1'b0;
    checkOutput("paused_running", int'(running), 0);
    repeat (20) @(negedge clk);
    checkDisp("paused_hold_40", 40);
    applyStimulus(1, 0, 0, 3);
    btn_ss = 1'b0;
    checkOutput("resume_running", int'(running), 1);
    checkDisp("resume_no_tick", 40);
    @(negedge clk);
    checkDisp("resume_phase_kept", 41);

    // Lap freeze at 0012 for ten ticks, then release shows 0022.
    applyStimulus(0, 1, 0, 3);
    btn_clr = 1'b0;
    checkOutput("clr_running", int'(running), 0);
    checkDisp("clr_display", 0);
    applyStimulus(1, 0, 0, 3);
    btn_ss = 1'b0;
    waitDisplay(12, 200);
    applyStimulus(0, 0, 1, 3);
    btn_lap = 1'b0;
    checkDisp("lap_latched", 12);
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      checkDisp("lap_frozen", 12);
    end
    btn_lap = 1'b1;
    @(negedge clk);
    btn_lap = 1'b0;
    checkDisp("lap_frozen_late", 12);
    @(negedge clk);
    checkDisp("lap_frozen_last", 12);
    @(negedge clk);
    checkDisp("lap_released", 22);

    // Simultaneous clear and start/stop while running with a lap held.
    applyStimulus(0, 0, 1, 3);
    btn_lap = 1'b0;
    applyStimulus(1, 1, 0, 3);
    btn_ss = 1'b0; btn_clr = 1'b0;
    checkOutput("clr_wins_running", int'(running), 0);
    checkDisp("clr_wins_display", 0);
    repeat (10) @(negedge clk);
    checkOutput("clr_wins_stays_idle", int'(running), 0);
    applyStimulus(1, 0, 0, 3);
    btn_ss = 1'b0;
    repeat (4) @(negedge clk);
    checkDisp("hold_released_live", 1);

    // A held button is a single event.
    changes = 0;
    prev_run = running;
    btn_ss = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (running != prev_run) changes++;
      prev_run = running;
    end
    btn_ss = 1'b0;
    checkOutput("held_ss_changes", changes, 1);
    checkOutput("held_ss_paused", int'(running), 0);

    // Overflow: 9999 -> 0000 with a single ovf cycle, still running.
    applyStimulus(0, 1, 0, 3);
    btn_clr = 1'b0;
    applyStimulus(1, 0, 0, 3);
    btn_ss = 1'b0;
    waitDisplay(9999, 45000);
    checkOutput("at_9999_ovf", int'(ovf), 0);
    checkDisp("at_9999", 9999);
    for (int i = 0; i < 8 && dispValue() != 0; i++) @(negedge clk);
    checkDisp("wrap_display", 0);
    checkOutput("wrap_ovf", int'(ovf), 1);
    checkOutput("wrap_running", int'(running), 1);
    @(negedge clk);
    checkOutput("wrap_ovf_one_cycle", int'(ovf), 0);

    // Randomized button activity with rare asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 6) btn_ss  = ~btn_ss;
      if ($urandom_range(0, 99) < 2) btn_clr = ~btn_clr;
      if ($urandom_range(0, 99) < 4) btn_lap = ~btn_lap;
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    applyStimulus(0, 0, 0, 4);

    // Asynchronous reset mid-count clears everything without a clock edge.
    applyStimulus(0, 1, 0, 3);
    btn_clr = 1'b0;
    applyStimulus(1, 0, 0, 3);
    btn_ss = 1'b0;
    repeat (22) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkDisp("async_rst_display", 0);
    checkOutput("async_rst_running", int'(running), 0);
    checkOutput("async_rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("post_rst_idle", int'(running), 0);
    checkDisp("post_rst_display", 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
